// File: rtl/bcd_updown_counter_if.sv
// Control/status bundle of the BCD up/down counter.
// Latency: none, wiring only.
// Backpressure: none, plain level signals.
//
// Members (all digit vectors carry digit 0 in bits [3:0]):
//   clear    - synchronous zero of the count
//   load     - load request, load_val - BCD value to load
//   en       - count enable, up - 1 = increment, 0 = decrement
//   digits   - registered BCD count
//   tc       - one-cycle wrap pulse
//   at_max   - count equals the terminal value
//   at_min   - count equals zero
//   load_err - one-cycle pulse when a load is rejected
interface bcd_updown_counter_if #(
  parameter int NUM_DIGITS = 2
);
  logic                    clear;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_val;
  logic                    en;
  logic                    up;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    tc;
  logic                    at_max;
  logic                    at_min;
  logic                    load_err;

  modport master (
    output clear, load, load_val, en, up,
    input  digits, tc, at_max, at_min, load_err
  );

  modport slave (
    input  clear, load, load_val, en, up,
    output digits, tc, at_max, at_min, load_err
  );
endinterface

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with wrap or saturate at 0 / MAX_VALUE, load and clear.
// Latency: one cycle from a sampled clear/load/en to the updated digits, tc and load_err.
// Backpressure: none; every enabled edge takes exactly one step.
//
// Ports:
//   clk   - system clock, all state changes on its rising edge
//   reset - synchronous, active-high
//   bus   - slave side of bcd_updown_counter_if (controls in, count and flags out)
module bcd_updown_counter #(
  parameter int NUM_DIGITS = 2,
  parameter int MAX_VALUE  = 59,
  parameter int WRAP       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  bcd_updown_counter_if.slave   bus
);

  localparam int W = 4 * NUM_DIGITS;

  // Reject illegal parameter sets at elaboration.
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("bcd_updown_counter: NUM_DIGITS must be in 1..8");
  end
  if (MAX_VALUE < 1 || MAX_VALUE > (10 ** NUM_DIGITS) - 1) begin : g_bad_max
    $error("bcd_updown_counter: MAX_VALUE must be in 1..10^NUM_DIGITS-1");
  end
  if (WRAP != 0 && WRAP != 1) begin : g_bad_wrap
    $error("bcd_updown_counter: WRAP must be 0 or 1");
  end

  // Binary-to-BCD conversion of the terminal value, evaluated at elaboration.
  function automatic logic [W-1:0] to_bcd(input int value);
    logic [W-1:0] r;
    int           v;
    r = '0;
    v = value;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VALUE);

  logic [W-1:0] digits_q;
  logic         tc_q;
  logic         load_err_q;

  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic         load_ok;
  logic         is_max;
  logic         is_min;

  // Flags decode the register only, so input activity cannot glitch them.
  assign is_max = (digits_q == MAX_BCD);
  assign is_min = (digits_q == '0);

  // Ripple BCD +1 / -1 across digits; a digit only changes while a
  // carry/borrow is still propagating into it.
  always_comb begin
    logic       carry;
    logic       borrow;
    logic [3:0] d;
    inc_val = digits_q;
    dec_val = digits_q;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = digits_q[4*i +: 4];
      if (carry) begin
        if (d == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = d + 4'd1;
          carry             = 1'b0;
        end
      end
      if (borrow) begin
        if (d == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = d - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  // With every digit <= 9 the packed vector orders like the decimal value,
  // so a plain vector compare against MAX_BCD is a valid range check.
  always_comb begin
    load_ok = (bus.load_val <= MAX_BCD);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bus.load_val[4*i +: 4] > 4'd9) begin
        load_ok = 1'b0;
      end
    end
  end

  // Priority: reset > clear > load > en.
  always_ff @(posedge clk) begin
    if (reset) begin
      digits_q   <= '0;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else if (bus.clear) begin
      digits_q   <= '0;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else if (bus.load) begin
      // A load cycle never steps, whether the load is taken or rejected.
      tc_q <= 1'b0;
      if (load_ok) begin
        digits_q   <= bus.load_val;
        load_err_q <= 1'b0;
      end else begin
        load_err_q <= 1'b1;
      end
    end else if (bus.en) begin
      load_err_q <= 1'b0;
      if (bus.up) begin
        if (is_max) begin
          if (WRAP != 0) begin
            digits_q <= '0;
            tc_q     <= 1'b1;
          end else begin
            tc_q <= 1'b0;
          end
        end else begin
          digits_q <= inc_val;
          tc_q     <= 1'b0;
        end
      end else begin
        if (is_min) begin
          if (WRAP != 0) begin
            digits_q <= MAX_BCD;
            tc_q     <= 1'b1;
          end else begin
            tc_q <= 1'b0;
          end
        end else begin
          digits_q <= dec_val;
          tc_q     <= 1'b0;
        end
      end
    end else begin
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end
  end

  assign bus.digits   = digits_q;
  assign bus.tc       = tc_q;
  assign bus.load_err = load_err_q;
  assign bus.at_max   = is_max;
  assign bus.at_min   = is_min;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: three instances (default 00..59 wrap,
// 00..59 saturate, 000..999 wrap) driven one at a time; expected outputs are
// queued when a step is driven and popped after the edge that produces them.
module tb_bcd_updown_counter;

  logic clk;
  logic rst0, rst1, rst2;

  bcd_updown_counter_if #(.NUM_DIGITS(2)) if0 ();
  bcd_updown_counter_if #(.NUM_DIGITS(2)) if1 ();
  bcd_updown_counter_if #(.NUM_DIGITS(3)) if2 ();

  bcd_updown_counter #(.NUM_DIGITS(2), .MAX_VALUE(59), .WRAP(1)) dut0 (
    .clk(clk), .reset(rst0), .bus(if0.slave)
  );
  bcd_updown_counter #(.NUM_DIGITS(2), .MAX_VALUE(59), .WRAP(0)) dut1 (
    .clk(clk), .reset(rst1), .bus(if1.slave)
  );
  bcd_updown_counter #(.NUM_DIGITS(3), .MAX_VALUE(999), .WRAP(1)) dut2 (
    .clk(clk), .reset(rst2), .bus(if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          which;
    logic [11:0] digits;
    logic        tc;
    logic        load_err;
    logic        at_max;
    logic        at_min;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Terminal values of the three instances, written out as BCD.
  logic [11:0] max_bcd [3];
  initial begin
    max_bcd[0] = 12'h059;
    max_bcd[1] = 12'h059;
    max_bcd[2] = 12'h999;
  end

  function automatic logic [11:0] bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic idle_all();
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    if0.clear = 0; if0.load = 0; if0.load_val = '0; if0.en = 0; if0.up = 0;
    if1.clear = 0; if1.load = 0; if1.load_val = '0; if1.en = 0; if1.up = 0;
    if2.clear = 0; if2.load = 0; if2.load_val = '0; if2.en = 0; if2.up = 0;
  endtask

  task automatic check_bit(input string tag, input string what, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s %s: observed %b expected %b", tag, what, obs, exp);
    end
  endtask

  // Drive one instance for one edge, queue its expected result, then compare.
  task automatic step(input int which, input logic rs, input logic cl, input logic ld,
                      input logic [11:0] lv, input logic e, input logic u,
                      input logic [11:0] ed, input logic etc, input logic ele,
                      input string tag);
    exp_t        x;
    logic [11:0] od;
    logic        otc, ole, omax, omin;
    idle_all();
    case (which)
      0: begin rst0 = rs; if0.clear = cl; if0.load = ld; if0.load_val = lv[7:0]; if0.en = e; if0.up = u; end
      1: begin rst1 = rs; if1.clear = cl; if1.load = ld; if1.load_val = lv[7:0]; if1.en = e; if1.up = u; end
      default: begin rst2 = rs; if2.clear = cl; if2.load = ld; if2.load_val = lv; if2.en = e; if2.up = u; end
    endcase
    x.which    = which;
    x.digits   = ed;
    x.tc       = etc;
    x.load_err = ele;
    x.at_max   = (ed == max_bcd[which]);
    x.at_min   = (ed == 12'h000);
    x.tag      = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    case (x.which)
      0: begin od = {4'h0, if0.digits}; otc = if0.tc; ole = if0.load_err; omax = if0.at_max; omin = if0.at_min; end
      1: begin od = {4'h0, if1.digits}; otc = if1.tc; ole = if1.load_err; omax = if1.at_max; omin = if1.at_min; end
      default: begin od = if2.digits; otc = if2.tc; ole = if2.load_err; omax = if2.at_max; omin = if2.at_min; end
    endcase
    checks++;
    assert (od === x.digits) else begin
      errors++;
      $error("FAIL %s digits: observed %h expected %h", x.tag, od, x.digits);
    end
    check_bit(x.tag, "tc", otc, x.tc);
    check_bit(x.tag, "load_err", ole, x.load_err);
    check_bit(x.tag, "at_max", omax, x.at_max);
    check_bit(x.tag, "at_min", omin, x.at_min);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_all();
    #2;

    // ---------------- default instance: 00..59, wrap ----------------
    step(0, 1, 0, 0, 12'h000, 0, 0, 12'h000, 0, 0, "reset0");
    for (int k = 1; k <= 60; k++)
      step(0, 0, 0, 0, 12'h000, 1, 1, (k == 60) ? 12'h000 : bcd(k), (k == 60), 0, "count_up");
    step(0, 0, 0, 0, 12'h000, 0, 1, 12'h000, 0, 0, "tc_one_cycle");
    step(0, 0, 0, 0, 12'h000, 1, 0, 12'h059, 1, 0, "down_wrap");
    step(0, 0, 0, 0, 12'h000, 1, 0, 12'h058, 0, 0, "down_after_wrap");
    step(0, 0, 0, 1, 12'h06A, 0, 0, 12'h058, 0, 1, "load_bad_digit");
    step(0, 0, 0, 1, 12'h060, 1, 1, 12'h058, 0, 1, "load_over_max");
    step(0, 0, 0, 1, 12'h045, 1, 1, 12'h045, 0, 0, "load_with_en");
    step(0, 0, 0, 0, 12'h000, 1, 1, 12'h046, 0, 0, "dir_up");
    step(0, 0, 0, 0, 12'h000, 1, 0, 12'h045, 0, 0, "dir_down");
    step(0, 0, 0, 0, 12'h000, 1, 1, 12'h046, 0, 0, "dir_up_again");
    step(0, 0, 0, 0, 12'h000, 0, 1, 12'h046, 0, 0, "hold");
    step(0, 0, 1, 1, 12'h033, 1, 1, 12'h000, 0, 0, "clear_over_load");
    step(0, 0, 0, 1, 12'h036, 0, 0, 12'h036, 0, 0, "load_36");
    step(0, 0, 0, 0, 12'h000, 1, 1, 12'h037, 0, 0, "count_to_37");
    step(0, 1, 1, 1, 12'h050, 1, 1, 12'h000, 0, 0, "reset_mid_count");
    step(0, 0, 0, 0, 12'h000, 1, 1, 12'h001, 0, 0, "first_after_reset");
    step(0, 0, 0, 1, 12'h0F0, 0, 0, 12'h001, 0, 1, "load_bad_upper");
    step(0, 1, 0, 1, 12'h0F0, 0, 0, 12'h000, 0, 0, "reset_mid_bad_load");

    // ---------------- saturating instance ----------------
    step(1, 1, 0, 0, 12'h000, 0, 0, 12'h000, 0, 0, "reset1");
    step(1, 0, 0, 1, 12'h059, 0, 0, 12'h059, 0, 0, "sat_load_59");
    for (int k = 0; k < 3; k++)
      step(1, 0, 0, 0, 12'h000, 1, 1, 12'h059, 0, 0, "sat_hold_max");
    step(1, 0, 0, 1, 12'h000, 0, 0, 12'h000, 0, 0, "sat_load_0");
    step(1, 0, 0, 0, 12'h000, 1, 0, 12'h000, 0, 0, "sat_hold_min");
    step(1, 0, 0, 0, 12'h000, 1, 1, 12'h001, 0, 0, "sat_leave_min");

    // ---------------- three-digit instance: 000..999 ----------------
    step(2, 1, 0, 0, 12'h000, 0, 0, 12'h000, 0, 0, "reset2");
    step(2, 0, 0, 1, 12'h099, 0, 0, 12'h099, 0, 0, "d3_load_099");
    step(2, 0, 0, 0, 12'h000, 1, 1, 12'h100, 0, 0, "d3_carry");
    step(2, 0, 0, 0, 12'h000, 1, 0, 12'h099, 0, 0, "d3_borrow");
    step(2, 0, 0, 1, 12'h999, 0, 0, 12'h999, 0, 0, "d3_load_999");
    step(2, 0, 0, 0, 12'h000, 1, 1, 12'h000, 1, 0, "d3_wrap_up");
    step(2, 0, 0, 0, 12'h000, 1, 0, 12'h999, 1, 0, "d3_wrap_down");
    step(2, 0, 0, 1, 12'h9A9, 0, 0, 12'h999, 0, 1, "d3_load_bad");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
